// File: rtl/zintack_if.sv
// zintack_if: Z80 interrupt bus bundle between peripherals, CPU pins and zintack.
// slave = the responder, master = the CPU/peripheral side that drives requests.
interface zintack_if #(
    parameter int NSRC = 4
);
    logic [NSRC-1:0] irq_in;
    logic            iorq_n;
    logic            m1_n;
    logic            int_n;
    logic [7:0]      vec_out;
    logic            vec_oe;
    logic [NSRC-1:0] ack_src;
    logic [NSRC-1:0] pend;

    modport slave (
        input  irq_in, iorq_n, m1_n,
        output int_n, vec_out, vec_oe, ack_src, pend
    );

    modport master (
        output irq_in, iorq_n, m1_n,
        input  int_n, vec_out, vec_oe, ack_src, pend
    );
endinterface

// File: rtl/zintack.sv
// zintack: Z80 IM2 interrupt acknowledge responder and vector source.
// Optional REQ timeout drop enabled by defining ZINTACK_TIMEOUT_EN.
module zintack #(
    parameter int         NSRC     = 4,
    parameter logic [7:0] VEC_BASE = 8'hF0,
    parameter int         TMO_LEN  = 32
) (
    input  logic      zclk,
    input  logic      rst_n,
    zintack_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    if (NSRC < 2 || NSRC > 8 || VEC_BASE[3:0] != 4'h0 ||
        TMO_LEN < 1 || TMO_LEN > 63) begin : g_bad_param
        $error("zintack: illegal parameter value");
    end

    logic [1:0]      state_q, state_d;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] ack_q, ack_d;
    logic [NSRC-1:0] rise, clr, sel_mask;
    logic [2:0]      sel_q, sel_d, first_idx;
    logic [7:0]      vec_q, vec_d;
    logic            int_n_q, int_n_d;
    logic            vec_oe_q, vec_oe_d;
    logic            inta;
`ifdef ZINTACK_TIMEOUT_EN
    localparam logic [5:0] TMO_LAST = 6'(TMO_LEN - 1);
    logic [5:0]      tmo_q, tmo_d;
`endif

    assign inta     = ~bus.iorq_n & ~bus.m1_n;
    assign rise     = bus.irq_in & ~irq_q;
    assign sel_mask = NSRC'(1) << sel_q;

    // Descending scan so the lowest pending index is the last one kept.
    always_comb begin
        first_idx = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend_q[i]) first_idx = 3'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        vec_d    = vec_q;
        int_n_d  = int_n_q;
        vec_oe_d = vec_oe_q;
        ack_d    = '0;
        clr      = '0;
`ifdef ZINTACK_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    state_d = S_REQ;
                    int_n_d = 1'b0;
                    sel_d   = first_idx;
                    vec_d   = VEC_BASE | {4'h0, first_idx, 1'b0};
`ifdef ZINTACK_TIMEOUT_EN
                    tmo_d   = 6'd0;
`endif
                end
            end
            S_REQ: begin
                if (inta) begin
                    state_d  = S_ACK;
                    int_n_d  = 1'b1;
                    vec_oe_d = 1'b1;
                    clr      = sel_mask;
                    ack_d    = sel_mask;
                end
`ifdef ZINTACK_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = S_DONE;
                    int_n_d = 1'b1;
                    clr     = sel_mask;
                end else begin
                    tmo_d = tmo_q + 6'd1;
                end
`endif
            end
            S_ACK: begin
                if (!inta) begin
                    state_d  = S_DONE;
                    vec_oe_d = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A new edge on the acked source survives its own clear.
        pend_d = (pend_q & ~clr) | rise;
    end

    always_ff @(posedge zclk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            irq_q    <= bus.irq_in;
            pend_q   <= '0;
            ack_q    <= '0;
            sel_q    <= 3'd0;
            vec_q    <= VEC_BASE;
            int_n_q  <= 1'b1;
            vec_oe_q <= 1'b0;
`ifdef ZINTACK_TIMEOUT_EN
            tmo_q    <= 6'd0;
`endif
        end else begin
            state_q  <= state_d;
            irq_q    <= bus.irq_in;
            pend_q   <= pend_d;
            ack_q    <= ack_d;
            sel_q    <= sel_d;
            vec_q    <= vec_d;
            int_n_q  <= int_n_d;
            vec_oe_q <= vec_oe_d;
`ifdef ZINTACK_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign bus.int_n   = int_n_q;
    assign bus.vec_out = vec_q;
    assign bus.vec_oe  = vec_oe_q;
    assign bus.ack_src = ack_q;
    assign bus.pend    = pend_q;
endmodule

// File: tb/tb_zintack.sv
// tb_zintack: table-driven directed bench for zintack (NSRC=4, VEC_BASE=F0).
// Hand sequences cover timeout/hold behaviour and reset during ACK.
module tb_zintack;
    logic zclk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 zclk = ~zclk;

    zintack_if #(.NSRC(4)) bus ();

    zintack #(
        .NSRC     (4),
        .VEC_BASE (8'hF0),
        .TMO_LEN  (32)
    ) dut (
        .zclk  (zclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] irq;
        logic       iorq_n;
        logic       m1_n;
        logic       int_n;
        logic       oe;
        logic [3:0] ack;
        logic [3:0] pend;
        logic [7:0] vec;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic row(input logic [3:0] irq, input logic io, input logic m1,
                       input logic in, input logic oe, input logic [3:0] ack,
                       input logic [3:0] pd, input logic [7:0] v);
        vec_t r;
        r.irq = irq; r.iorq_n = io; r.m1_n = m1;
        r.int_n = in; r.oe = oe; r.ack = ack; r.pend = pd; r.vec = v;
        tv.push_back(r);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        logic ack_seen;
        logic got_req;

        //   irq      io    m1    int   oe    ack      pend     vec
        row(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'hF0);
        row(4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0001, 8'hF0);
        row(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0001, 8'hF0);
        row(4'b0001, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 4'b0000, 8'hF0);
        row(4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'hF0);
        row(4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'hF0);
        row(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0110, 8'hF0);
        row(4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0110, 8'hF2);
        row(4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 4'b0100, 8'hF2);
        row(4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0100, 8'hF2);
        row(4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0100, 8'hF2);
        row(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 8'hF2);
        row(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0100, 8'hF2);
        row(4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100, 8'hF4);
        row(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0100, 8'hF4);
        row(4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100, 8'hF4);
        row(4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100, 4'b0000, 8'hF4);
        row(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'hF4);
        row(4'b0111, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'hF4);
        row(4'b0111, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'hF4);
        row(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'hF4);
        row(4'b0101, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'hF4);
        row(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010, 8'hF4);
        row(4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 8'hF2);
        row(4'b0101, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 4'b0000, 8'hF2);
        row(4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0010, 8'hF2);
        row(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010, 8'hF2);
        row(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010, 8'hF2);
        row(4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 8'hF2);
        row(4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 4'b0010, 8'hF2);
        row(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010, 8'hF2);
        row(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0010, 8'hF2);
        row(4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0010, 8'hF2);
        row(4'b0111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010, 4'b0000, 8'hF2);
        row(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'hF2);
        row(4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 8'hF2);
        row(4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 8'hF2);
        row(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1000, 8'hF6);

        // Reset with source 0 already high: no edge at release.
        rst_n = 1'b0;
        bus.irq_in = 4'b0001;
        bus.iorq_n = 1'b1;
        bus.m1_n   = 1'b1;
        repeat (2) @(posedge zclk);
        #1;
        check("rst_int_n", 32'(bus.int_n), 32'd1);
        check("rst_vec_oe", 32'(bus.vec_oe), 32'd0);
        check("rst_vec_out", 32'(bus.vec_out), 32'hF0);
        check("rst_ack_src", 32'(bus.ack_src), 32'd0);
        check("rst_pend", 32'(bus.pend), 32'd0);
        @(negedge zclk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge zclk);
            #1;
            check($sformatf("lvl%0d_pend", i), 32'(bus.pend), 32'd0);
            check($sformatf("lvl%0d_int_n", i), 32'(bus.int_n), 32'd1);
        end

        foreach (tv[i]) begin
            @(negedge zclk);
            bus.irq_in = tv[i].irq;
            bus.iorq_n = tv[i].iorq_n;
            bus.m1_n   = tv[i].m1_n;
            @(posedge zclk);
            #1;
            check($sformatf("row%0d_int_n", i), 32'(bus.int_n), 32'(tv[i].int_n));
            check($sformatf("row%0d_vec_oe", i), 32'(bus.vec_oe), 32'(tv[i].oe));
            check($sformatf("row%0d_ack", i), 32'(bus.ack_src), 32'(tv[i].ack));
            check($sformatf("row%0d_pend", i), 32'(bus.pend), 32'(tv[i].pend));
            check($sformatf("row%0d_vec", i), 32'(bus.vec_out), 32'(tv[i].vec));
        end

        // Source 3 is now requesting with no acknowledge from the CPU.
        ack_seen = 1'b0;
`ifdef ZINTACK_TIMEOUT_EN
        low = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge zclk);
            #1;
            if (bus.ack_src != 4'b0000) ack_seen = 1'b1;
            if (bus.int_n) break;
            low++;
        end
        check("tmo_low_cycles", 32'(low), 32'd32);
        check("tmo_pend", 32'(bus.pend), 32'd0);
        check("tmo_no_ack", 32'(ack_seen), 32'd0);
`else
        low = 0;
        repeat (1000) begin
            @(posedge zclk);
            #1;
            if (bus.ack_src != 4'b0000) ack_seen = 1'b1;
            if (!bus.int_n) low++;
        end
        check("hold_low_cycles", 32'(low), 32'd1000);
        check("hold_int_n", 32'(bus.int_n), 32'd0);
        check("hold_no_ack", 32'(ack_seen), 32'd0);
        check("hold_pend", 32'(bus.pend), 32'b1000);
`endif

        // Reset while in ACK with vec_oe high.
        @(negedge zclk);
        bus.irq_in = 4'b0000;
        @(negedge zclk);
        bus.irq_in = 4'b0101;
        got_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge zclk);
            if (!bus.int_n) begin
                got_req = 1'b1;
                break;
            end
        end
        check("mid_req_seen", 32'(got_req), 32'd1);
        bus.iorq_n = 1'b0;
        bus.m1_n   = 1'b0;
        @(posedge zclk);
        #1;
        check("mid_vec_oe", 32'(bus.vec_oe), 32'd1);
        check("mid_pend2", 32'(bus.pend[2]), 32'd1);
        @(negedge zclk);
        rst_n = 1'b0;
        @(posedge zclk);
        #1;
        check("mrst_vec_oe", 32'(bus.vec_oe), 32'd0);
        check("mrst_int_n", 32'(bus.int_n), 32'd1);
        check("mrst_pend", 32'(bus.pend), 32'd0);
        check("mrst_ack", 32'(bus.ack_src), 32'd0);
        check("mrst_vec", 32'(bus.vec_out), 32'hF0);
        @(negedge zclk);
        rst_n = 1'b1;
        bus.iorq_n = 1'b1;
        bus.m1_n   = 1'b1;
        repeat (3) @(posedge zclk);
        #1;
        check("post_int_n", 32'(bus.int_n), 32'd1);
        check("post_pend", 32'(bus.pend), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
